mersenne_candidate_gen: RTL
===========================

MERSENNE_CANDIDATE_GEN -- requirements
Module: mersenne_candidate_gen

Interface
REQ-001 The block SHALL have parameter BITWIDTH, default 32: width of p, d and k.
REQ-002 The block SHALL have these ports:
  sys_clk  in  1  clock, rising edge
  sys_rst_n  in  1  reset, asynchronous, active-low
  cmd_valid  in  1  job request
  cmd_ready  out  1  job accepted when high with cmd_valid
  cmd_p  in  BITWIDTH  Mersenne exponent p
  cmd_kmax  in  BITWIDTH  last k to try
  tst_start  out  1  one-cycle launch pulse to the factor tester
  tst_p  out  BITWIDTH  exponent to the tester
  tst_d  out  BITWIDTH  candidate divisor to the tester
  tst_hit  in  1  tester verdict: 2^p mod d == 1
  tst_finished  in  1  tester idle (high when not computing)
  res_valid  out  1  result available
  res_ready  in  1  result consumed when high with res_valid
  res_found  out  1  factor found
  res_d  out  BITWIDTH  factor, or last d tested
  res_k  out  BITWIDTH  k of res_d
  busy  out  1  high in every state except IDLE

Function
REQ-003 The block SHALL generate candidates d = 2*k*p + 1 for k = 1..kmax, in increasing order.
REQ-004 The block SHALL compute d incrementally (d += 2p per step) and SHALL NOT use a multiplier.
REQ-005 The block SHALL launch the tester only for candidates with d[2:0] equal to 3'b001 or 3'b111; other candidates SHALL be skipped at one cycle each.
REQ-006 The FSM SHALL have states IDLE, STEP, LAUNCH, WAIT_LO, WAIT_HI, REPORT.
REQ-007 In IDLE, cmd_ready SHALL be 1; cmd_ready SHALL be 0 in every other state.
REQ-008 When cmd_valid and cmd_ready are both high, the block SHALL latch p and kmax, set k=1 and d=2p+1, and enter STEP.
REQ-009 The block SHALL go directly to REPORT with found=0, k=0 and d=0 if p is even, p<3, or kmax=0.
REQ-010 In STEP, the block SHALL do exactly one of the following:
  - k>kmax: go to REPORT with found=0;
  - filter pass: go to LAUNCH;
  - filter fail: advance k and d, then stay in STEP.
REQ-011 If d+2p overflows BITWIDTH bits, the block SHALL treat it as k>kmax (exhausted), leaving res_k/res_d at the last generated candidate.
REQ-012 LAUNCH SHALL assert tst_start for exactly one cycle, with tst_p and tst_d stable from that cycle until the block leaves WAIT_HI, and SHALL then go to WAIT_LO.
REQ-013 WAIT_LO SHALL wait for tst_finished=0 before entering WAIT_HI.
REQ-014 WAIT_HI SHALL wait for tst_finished=1, then sample tst_hit in that same cycle:
  - hit: go to REPORT with found=1, res_d=d, res_k=k;
  - no hit: advance k and d, then go to STEP.
REQ-015 The block SHALL stop on the first factor found.
REQ-016 On exhaustion, res_found SHALL be 0, res_k SHALL be the last k generated, and res_d SHALL be the matching d.
REQ-017 In REPORT, res_valid SHALL be 1 and res_found, res_d and res_k SHALL hold stable until res_ready=1; the block SHALL then return to IDLE on the next edge.
REQ-018 A new command SHALL NOT be accepted in the same cycle as a result handshake; it is accepted in IDLE one cycle later at the earliest.
REQ-019 tst_start SHALL never assert outside LAUNCH.

Reset
REQ-020 Asserting sys_rst_n low SHALL immediately force:
  - state IDLE;
  - tst_start, res_valid, res_found and busy to 0;
  - res_d, res_k, tst_p, tst_d and internal k, d, p, kmax to 0;
  - cmd_ready to 1.
REQ-021 A reset during any state, including mid-launch, SHALL abandon the job with no result and no further tst_start pulse.

Structure
REQ-022 Package mersenne_pkg SHALL hold the BITWIDTH default and the FSM state enum; both are shared with the factor tester and the top level.
REQ-023 The incremental step logic SHALL be a sub-module, mersenne_cand_step (combinational), which computes next d, overflow and the mod-8 filter pass.

Verification
REQ-024 The bench SHALL drive the tester interface from a behavioural model that computes 2^p mod d and deasserts tst_finished for a random 1-40 cycles after tst_start, and SHALL cover:
  - p=11, kmax=10 -> one launch (d=23); res_found=1, res_d=23, res_k=1.
  - p=29, kmax=8 -> k=1 (d=59) and k=2 (d=117) skipped; launches d=175 then d=233; res_found=1, res_d=233, res_k=4.
  - p=7, kmax=4 -> launches d=15 and d=57 only; res_found=0, res_d=57, res_k=4.
  - BITWIDTH=8, p=127, kmax=5 -> launch d=255; the next step overflows; res_found=0, res_k=1, res_d=255.
  - p=10 (even) or kmax=0 -> no tst_start; res_valid within 2 cycles of the command; res_found=0, res_k=0; res_ready held low for 5 cycles -> outputs stable throughout.
  - reset asserted in WAIT_HI -> immediately IDLE, cmd_ready=1; tester completion afterwards produces no result; a new job (p=11) then completes normally.

Source files
------------

// File: rtl/mersenne_pkg.sv
// Shared width default, FSM encoding and candidate filter
// for the Mersenne trial-factor search.
package mersenne_pkg;

  localparam int BITWIDTH_DEF = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_STEP,
    ST_LAUNCH,
    ST_WAIT_LO,
    ST_WAIT_HI,
    ST_REPORT
  } mc_state_e;

  // Factors of 2^p-1 are +/-1 mod 8.
  function automatic logic mod8_ok(input logic [2:0] lsb);
    return (lsb == 3'b001) || (lsb == 3'b111);
  endfunction

endpackage

// File: rtl/mersenne_cand_step.sv
// Next-candidate adder: d + 2p with carry-out detection,
// plus the mod-8 filter on the current candidate.
module mersenne_cand_step
  import mersenne_pkg::*;
#(
  parameter int BITWIDTH = BITWIDTH_DEF
) (
  input  logic [BITWIDTH-1:0] d,
  input  logic [BITWIDTH-1:0] p,
  output logic [BITWIDTH-1:0] d_next,
  output logic                ovf,
  output logic                pass
);

  logic [BITWIDTH+1:0] sum;

  always_comb begin
    sum    = {2'b00, d} + {1'b0, p, 1'b0};
    d_next = sum[BITWIDTH-1:0];
    ovf    = |sum[BITWIDTH+1:BITWIDTH];
    pass   = mod8_ok(d[2:0]);
  end

endmodule

// File: rtl/mersenne_candidate_gen.sv
// Walks d = 2kp+1 for k = 1..kmax, filters mod 8 and hands
// survivors to an external factor tester until a hit.
module mersenne_candidate_gen
  import mersenne_pkg::*;
#(
  parameter int BITWIDTH = BITWIDTH_DEF
) (
  input  logic                sys_clk,
  input  logic                sys_rst_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [BITWIDTH-1:0] cmd_p,
  input  logic [BITWIDTH-1:0] cmd_kmax,
  output logic                tst_start,
  output logic [BITWIDTH-1:0] tst_p,
  output logic [BITWIDTH-1:0] tst_d,
  input  logic                tst_hit,
  input  logic                tst_finished,
  output logic                res_valid,
  input  logic                res_ready,
  output logic                res_found,
  output logic [BITWIDTH-1:0] res_d,
  output logic [BITWIDTH-1:0] res_k,
  output logic                busy
);

  mc_state_e           state;
  logic [BITWIDTH-1:0] p_q;
  logic [BITWIDTH-1:0] kmax_q;
  logic [BITWIDTH-1:0] k_q;
  logic [BITWIDTH-1:0] d_q;
  logic                ovf_q;

  logic [BITWIDTH-1:0] d_next;
  logic                step_ovf;
  logic                step_pass;
  logic [BITWIDTH-1:0] d_first;
  logic                bad_cmd;

  // A set MSB in p means 2p+1 itself cannot be represented.
  assign d_first = {cmd_p[BITWIDTH-2:0], 1'b1};
  assign bad_cmd = !cmd_p[0]
                || (cmd_p < BITWIDTH'(3))
                || (cmd_kmax == '0)
                || cmd_p[BITWIDTH-1];

  mersenne_cand_step #(
    .BITWIDTH(BITWIDTH)
  ) u_step (
    .d      (d_q),
    .p      (p_q),
    .d_next (d_next),
    .ovf    (step_ovf),
    .pass   (step_pass)
  );

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state     <= ST_IDLE;
      p_q       <= '0;
      kmax_q    <= '0;
      k_q       <= '0;
      d_q       <= '0;
      ovf_q     <= 1'b0;
      cmd_ready <= 1'b1;
      busy      <= 1'b0;
      tst_start <= 1'b0;
      tst_p     <= '0;
      tst_d     <= '0;
      res_valid <= 1'b0;
      res_found <= 1'b0;
      res_d     <= '0;
      res_k     <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            p_q       <= cmd_p;
            kmax_q    <= cmd_kmax;
            ovf_q     <= 1'b0;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            res_found <= 1'b0;
            res_d     <= '0;
            res_k     <= '0;
            if (bad_cmd) begin
              k_q       <= '0;
              d_q       <= '0;
              res_valid <= 1'b1;
              state     <= ST_REPORT;
            end else begin
              k_q   <= BITWIDTH'(1);
              d_q   <= d_first;
              state <= ST_STEP;
            end
          end
        end

        ST_STEP: begin
          if (ovf_q || (k_q > kmax_q)) begin
            res_valid <= 1'b1;
            state     <= ST_REPORT;
          end else if (step_pass) begin
            tst_start <= 1'b1;
            tst_p     <= p_q;
            tst_d     <= d_q;
            state     <= ST_LAUNCH;
          end else begin
            // res_k/res_d track the last candidate finished.
            res_k <= k_q;
            res_d <= d_q;
            if (step_ovf) begin
              ovf_q <= 1'b1;
            end else begin
              k_q <= k_q + BITWIDTH'(1);
              d_q <= d_next;
            end
          end
        end

        ST_LAUNCH: begin
          tst_start <= 1'b0;
          state     <= ST_WAIT_LO;
        end

        ST_WAIT_LO: begin
          if (!tst_finished) state <= ST_WAIT_HI;
        end

        ST_WAIT_HI: begin
          if (tst_finished) begin
            if (tst_hit) begin
              res_found <= 1'b1;
              res_k     <= k_q;
              res_d     <= d_q;
              res_valid <= 1'b1;
              state     <= ST_REPORT;
            end else begin
              res_k <= k_q;
              res_d <= d_q;
              if (step_ovf) begin
                ovf_q <= 1'b1;
              end else begin
                k_q <= k_q + BITWIDTH'(1);
                d_q <= d_next;
              end
              state <= ST_STEP;
            end
          end
        end

        ST_REPORT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            state     <= ST_IDLE;
          end
        end

        default: begin
          tst_start <= 1'b0;
          res_valid <= 1'b0;
          cmd_ready <= 1'b1;
          busy      <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
